// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory stream loader.
// Frame on the wire: LEN_LO, LEN_HI, N*4 data bytes (little-endian words), CSUM.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } loader_state_e;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  // True in the states that take bytes from the stream.
  function automatic logic state_takes_bytes(loader_state_e s);
    return (s != S_DONE) && (s != S_ERR);
  endfunction

endpackage

// File: rtl/imem_stream_loader_byte_packer.sv
// Assembles accepted stream bytes into little-endian 32-bit words.
// word_valid_o pulses for one cycle after the 4th byte of a word; word_o is valid then.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        acc_i,
  input  logic [7:0]  data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] sr_q, sr_d;
  logic        word_valid_q, word_valid_d;

  always_comb begin
    lane_d       = lane_q;
    sr_d         = sr_q;
    word_valid_d = 1'b0;
    if (clr_i) begin
      lane_d = '0;
      sr_d   = '0;
    end else if (acc_i) begin
      // Shift right so the first byte of a word ends up in bits 7:0.
      sr_d         = {data_i, sr_q[31:8]};
      lane_d       = lane_q + 2'd1;
      word_valid_d = (lane_q == 2'd3);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q       <= '0;
      sr_q         <= '0;
      word_valid_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      sr_q         <= sr_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = sr_q;

endmodule

// File: rtl/imem_stream_loader.sv
// Boot loader: receives a length-prefixed, XOR-checked byte image and writes it into
// instruction memory, holding the core in reset until the image is verified.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready; in_ready is
// registered, high in every frame state, and in_valid carries no hold requirement.
module imem_stream_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state_o
);

  localparam int REM_W = 8 * LEN_BYTES + $clog2(WORD_BYTES);

  loader_state_e     state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [7:0]        xor_q, xor_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic              in_ready_q, in_ready_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic [15:0]       len_w;
  logic              pk_acc;
  logic              pk_clr;
  logic              pk_word_valid;
  logic [31:0]       pk_word;

  assign accept = in_valid && in_ready_q;
  assign len_w  = {in_data, len_lo_q};

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (pk_clr),
    .acc_i        (pk_acc),
    .data_i       (in_data),
    .word_valid_o (pk_word_valid),
    .word_o       (pk_word)
  );

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    rem_d    = rem_q;
    xor_d    = xor_q;
    wcnt_d   = wcnt_q;
    pk_acc   = 1'b0;
    pk_clr   = 1'b0;

    // Advance the word index once the packer has issued a write.
    if (pk_word_valid) begin
      wcnt_d = wcnt_q + 1'b1;
    end

    unique case (state_q)
      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = in_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          if (32'(len_w) > MAX_WORDS) begin
            state_d = S_ERR;
          end else if (len_w == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            rem_d   = REM_W'(len_w) * REM_W'(WORD_BYTES);
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          pk_acc = 1'b1;
          xor_d  = xor_q ^ in_data;
          rem_d  = rem_q - 1'b1;
          if (rem_q == REM_W'(1)) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (in_data == xor_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          pk_clr  = 1'b1;
          xor_d   = '0;
          wcnt_d  = '0;
          rem_d   = '0;
          state_d = S_LEN_LO;
        end
      end
      default: state_d = S_LEN_LO;
    endcase

    // Status outputs are registered copies of what the next state implies.
    im_addr_d  = BASE_ADDR + (wcnt_d << 2);
    in_ready_d = state_takes_bytes(state_d);
    core_rst_d = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LEN_LO;
      len_lo_q   <= '0;
      rem_q      <= '0;
      xor_q      <= '0;
      wcnt_q     <= '0;
      im_addr_q  <= BASE_ADDR;
      in_ready_q <= 1'b1;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      rem_q      <= rem_d;
      xor_q      <= xor_d;
      wcnt_q     <= wcnt_d;
      im_addr_q  <= im_addr_d;
      in_ready_q <= in_ready_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign im_we       = pk_word_valid;
  assign im_addr     = im_addr_q;
  assign im_wdata    = pk_word;
  assign core_rst    = core_rst_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Bench for imem_stream_loader: frame-level reference model checked every cycle,
// plus hand-computed write and status expectations for each directed frame.
module tb_imem_stream_loader;

  localparam int unsigned ADDR_W    = 32;
  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam int unsigned MAX_WORDS = 4;

  localparam int PH_LEN_LO = 0;
  localparam int PH_LEN_HI = 1;
  localparam int PH_DATA   = 2;
  localparam int PH_CSUM   = 3;
  localparam int PH_DONE   = 4;
  localparam int PH_ERR    = 5;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        core_rst;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  imem_stream_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .im_we       (im_we),
    .im_addr     (im_addr),
    .im_wdata    (im_wdata),
    .core_rst    (core_rst),
    .done        (done),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];
  logic [7:0]  tx_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  int          m_ph  = PH_LEN_LO;
  int          m_n   = 0;
  int          m_cnt = 0;
  logic [7:0]  m_xor = 8'h00;
  logic [31:0] m_word = 32'h0;
  logic        e_we = 1'b0, e_ready = 1'b1, e_done = 1'b0, e_err = 1'b0, e_core_rst = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_im_we",    64'(im_we),    64'd0);
      chk("rst_im_addr",  64'(im_addr),  64'(BASE));
      chk("rst_im_wdata", 64'(im_wdata), 64'd0);
      chk("rst_core_rst", 64'(core_rst), 64'd1);
      chk("rst_done",     64'(done),     64'd0);
      chk("rst_err",      64'(err),      64'd0);
      m_ph = PH_LEN_LO; m_n = 0; m_cnt = 0; m_xor = 8'h00; m_word = 32'h0;
      e_we = 1'b0; e_ready = 1'b1; e_done = 1'b0; e_err = 1'b0; e_core_rst = 1'b1;
      exp_q.delete();
    end else begin
      chk("im_we", 64'(im_we), 64'(e_we));
      if (im_we) begin
        wlog_addr.push_back(im_addr);
        wlog_data.push_back(im_wdata);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL write_unexpected: got addr %h data %h expected no write", im_addr, im_wdata);
        end else begin
          chk("write_addr_data", {im_addr, im_wdata}, exp_q.pop_front());
        end
      end
      chk("in_ready", 64'(in_ready), 64'(e_ready));
      chk("done",     64'(done),     64'(e_done));
      chk("err",      64'(err),      64'(e_err));
      chk("core_rst", 64'(core_rst), 64'(e_core_rst));

      // Effect of the inputs presented now, at the coming rising edge.
      e_we = 1'b0;
      if (start && (m_ph == PH_DONE || m_ph == PH_ERR)) begin
        m_ph = PH_LEN_LO; m_cnt = 0; m_xor = 8'h00;
      end else if (in_valid && m_ph < PH_DONE) begin
        case (m_ph)
          PH_LEN_LO: begin m_n = int'(in_data); m_ph = PH_LEN_HI; end
          PH_LEN_HI: begin
            m_n = m_n + 256 * int'(in_data);
            m_cnt = 0;
            if (m_n > int'(MAX_WORDS)) m_ph = PH_ERR;
            else if (m_n == 0)         m_ph = PH_CSUM;
            else                       m_ph = PH_DATA;
          end
          PH_DATA: begin
            m_word[8*(m_cnt%4) +: 8] = in_data;
            m_xor = m_xor ^ in_data;
            m_cnt++;
            if (m_cnt % 4 == 0) begin
              e_we = 1'b1;
              exp_q.push_back({BASE + 32'(4 * (m_cnt / 4 - 1)), m_word});
            end
            if (m_cnt == 4 * m_n) m_ph = PH_CSUM;
          end
          default: m_ph = (in_data == m_xor) ? PH_DONE : PH_ERR;
        endcase
      end
      e_ready    = (m_ph < PH_DONE);
      e_done     = (m_ph == PH_DONE);
      e_err      = (m_ph == PH_ERR);
      e_core_rst = (m_ph != PH_DONE);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_q(input int max_gap);
    logic [7:0] b;
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send_byte(b);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic chk_write(input string name, input int idx, input logic [31:0] a, input logic [31:0] d);
    logic [63:0] act;
    act = (idx < wlog_addr.size()) ? {wlog_addr[idx], wlog_data[idx]} : 64'hx;
    chk(name, act, {a, d});
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Two words, correct checksum (0x13^0x50^0x93^0x01^0xA0 = 0x71).
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h01, 8'hA0, 8'h00, 8'h71};
    send_q(0);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_core_rst", 64'(core_rst), 64'd0);
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_nwrites", 64'(wlog_addr.size()), 64'd2);
    chk_write("t1_w0", 0, BASE, 32'h0050_0013);
    chk_write("t1_w1", 1, BASE + 32'd4, 32'h00A0_0193);
    idle(2);

    // Same image, wrong checksum: writes still land, core stays in reset.
    pulse_start();
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h01, 8'hA0, 8'h00, 8'h70};
    send_q(0);
    chk("t2_err", 64'(err), 64'd1);
    chk("t2_core_rst", 64'(core_rst), 64'd1);
    chk("t2_done", 64'(done), 64'd0);
    chk_write("t2_w1", 3, BASE + 32'd4, 32'h00A0_0193);
    idle(2);

    // Empty image.
    pulse_start();
    tx_q = '{8'h00, 8'h00, 8'h00};
    send_q(0);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_nwrites", 64'(wlog_addr.size()), 64'd4);
    idle(2);

    // Length one past the limit; trailing bytes must be ignored.
    pulse_start();
    tx_q = '{8'h05, 8'h00};
    send_q(0);
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_in_ready", 64'(in_ready), 64'd0);
    tx_q = '{8'h11, 8'h22, 8'h33};
    send_q(0);
    chk("t4_nwrites", 64'(wlog_addr.size()), 64'd4);
    idle(2);

    // Reset mid-word, then a fresh one-word frame.
    pulse_start();
    tx_q = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send_q(0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    chk("t5_after_rst_nwrites", 64'(wlog_addr.size()), 64'd4);
    tx_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_q(0);
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_nwrites", 64'(wlog_addr.size()), 64'd5);
    chk_write("t5_w0", 4, BASE, 32'h4433_2211);
    idle(2);

    // Gappy three-word frame with an ignored start mid-data (XOR of 1..12 = 0x0C).
    pulse_start();
    tx_q = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_q(2);
    pulse_start();
    tx_q = '{8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0C};
    send_q(2);
    chk("t6_done", 64'(done), 64'd1);
    chk_write("t6_w2", 7, BASE + 32'd8, 32'h0C0B_0A09);
    idle(2);

    // Reload: addresses restart at BASE, core held in reset throughout.
    pulse_start();
    tx_q = '{8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE};
    send_q(1);
    chk("t7_core_rst_mid", 64'(core_rst), 64'd1);
    tx_q = '{8'hEF, 8'h10, 8'h20, 8'h30, 8'h40, 8'h62};
    send_q(1);
    chk("t7_done", 64'(done), 64'd1);
    chk("t7_nwrites", 64'(wlog_addr.size()), 64'd10);
    chk_write("t7_w0", 8, BASE, 32'hEFBE_ADDE);
    chk_write("t7_w1", 9, BASE + 32'd4, 32'h4030_2010);

    idle(3);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
